// File: rtl/mul8_shift_add_ctrl_pkg.sv
// Shared types and constants for the shift-add multiplier.
// State encoding and default widths.
package mul8_shift_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul8_shift_add_ctrl_fa8b.sv
// 8-bit ripple-carry adder built from full-adder cells.
// Shared by the sequential and array multipliers.
module FA8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_fa
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) |
                      (a[i] & c[i]) |
                      (b[i] & c[i]);
    end
  endgenerate

  assign cout = c[8];

endmodule

// File: rtl/mul8_shift_add_ctrl.sv
// Sequential shift-add multiplier: one adder reused over
// WIDTH iterations, valid/ready on both sides.
module mul8_shift_add_ctrl
  import mul8_shift_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             last;

  assign addend = mq[0] ? mcand : '0;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  FA8b u_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE: state_n = (in_valid && in_ready) ? RUN : IDLE;
      RUN:  state_n = last ? DONE : RUN;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: in_ready  = rst_n;
      RUN:  busy      = 1'b1;
      DONE: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture and per-iteration add-and-shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
    end else if (state == IDLE && in_valid && in_ready) begin
      cnt   <= '0;
      mcand <= a;
      acc   <= '0;
      mq    <= b;
    end else if (state == RUN) begin
      cnt   <= cnt + CNT_W'(1);
      acc   <= {cout, sum[WIDTH-1:1]};
      mq    <= {sum[0], mq[WIDTH-1:1]};
    end
  end

  assign product = {acc, mq};

endmodule

// File: doc/mul8_shift_add_ctrl.md
Name: mul8_shift_add_ctrl

Overview:
Sequential shift-add multiplier controller. It time-shares one WIDTH-bit ripple-carry adder across WIDTH iterations to produce a 2*WIDTH-bit unsigned product. It sits between an operand source and a result consumer, with a valid/ready handshake on each side. It is the area-minimal alternative to the array multiplier built from the same adder.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits. Only 8 is required to be supported with the 8-bit adder.
CNT_W, 3, iteration counter width; must equal clog2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
in_valid  input  1  operands A, B valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  unsigned A*B
busy  output  1  high in RUN state

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low. Every register loads its reset value on a rising clk while rst_n=0.
- Reset values: state=IDLE, cnt=0, mcand=0, acc=0, mq=0, product=0, out_valid=0, busy=0.
- in_ready is forced to 0 while rst_n=0. Otherwise in_ready=1 exactly when state=IDLE.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - RUN: in_ready=0, out_valid=0, busy=1.
  - DONE: in_ready=0, out_valid=1, busy=0.
- IDLE -> RUN on an edge with in_valid&in_ready. On that edge: mcand<=a, mq<=b, acc<=0, cnt<=0.
- RUN, each cycle:
  - Adder inputs are acc and (mq[0] ? mcand : 0), with carry-in 0. Adder output is sum[WIDTH:0], including carry-out.
  - Update {acc,mq} <= {sum[WIDTH:0], mq[WIDTH-1:1]}. This is the (2*WIDTH+1)-bit concatenation truncated to its top 2*WIDTH bits, i.e. a right shift by one.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, transition to DONE on that edge.
- DONE: product={acc,mq}, held stable while out_valid=1. On an edge with out_ready=1, transition to IDLE.
- No back-to-back acceptance in the DONE cycle.
- Latency:
  - out_valid rises WIDTH edges after the accepting edge (8 for WIDTH=8).
  - Minimum accept-to-accept spacing is WIDTH+2 cycles when out_ready is tied high.
- Width rule: the intermediate sum never exceeds WIDTH+1 bits. Product range is 0..(2^WIDTH-1)^2, so the final product never overflows.
- in_valid while in RUN/DONE: ignored. Operands are not captured and no state changes.
- a and b may change after acceptance without affecting the result, because mcand and mq are latched.
- out_ready high before DONE: no effect. out_ready low in DONE: hold DONE indefinitely with product stable.
- Reset mid-RUN or mid-DONE: next state IDLE and all registers return to their reset values. The partial result is discarded and no out_valid pulse occurs.
- Counter wrap: cnt is never incremented outside RUN. The RUN exit is at cnt==WIDTH-1, so cnt does not wrap while running.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10 (2'b11 is illegal and recovers to IDLE);
  - WIDTH default;
  - CNT_W.
- One sub-module: instantiate the team's existing 8-bit ripple-carry adder FA8b for the per-iteration add.
- The controller holds only state, counter and registers; no other arithmetic.

Test Plan:
1. Reset, then in_valid pulse with a=200, b=190 and out_ready=1. Required: in_ready drops the next cycle; out_valid rises 8 edges after acceptance with product=38000 (0x9470); IDLE one cycle later.
2. a=255, b=255 -> product=65025 (0xFE01). Also a=0, b=173 -> 0, and a=173, b=0 -> 0. All at the same 8-cycle latency.
3. Backpressure: a=144, b=89 with out_ready=0 for 5 cycles after out_valid. Required: product=12816 stays stable, in_ready stays 0, and in_valid with new operands is ignored. Raising out_ready returns the controller to IDLE after one edge.
4. Busy-ignore: accept a=20, b=50, then hold in_valid=1 with a=249, b=153 throughout RUN. Required: product=1000. The second pair is accepted only after returning to IDLE and yields 38097.
5. Reset mid-operation: accept a=80, b=255, then drop rst_n for one cycle at iteration 4. Required: out_valid never asserts for that operation; state=IDLE and product=0 after reset. A following a=189, b=190 -> 35910.
6. Throughput: out_ready tied 1, in_valid tied 1 with random operands over 1000 operations. Required: accept spacing is exactly 10 cycles and every product matches a reference model.
